alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Parametrised multi-cycle multiply/divide unit for the RV64M/RV32M M-extension, including the W-variants.
- Sits beside the single-cycle arithmetic unit in the ALU. The execute stage routes M-extension ops here and stalls on the handshake.
- The multiplier is iterative shift-add and the divider is restoring. Both retire UNROLL bits per cycle.
- Divide-by-zero and signed overflow take a fast path and complete early.

Parameters:
- WIDTH, 64, datapath width. Legal values are 32 or 64.
- UNROLL, 1, bits retired per iteration. Legal values are 1, 2 or 4, and UNROLL must divide 32.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- flush  input  1  abort any in-flight op and return to IDLE
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request
- md_op  input  4  op code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW; 13-15 are invalid
- op_a  input  WIDTH  rs1 operand
- op_b  input  WIDTH  rs2 operand
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- result  output  WIDTH  final result
- div_by_zero  output  1  completed op was a divide/remainder with a zero divisor
- invalid_op  output  1  completed op code was 13-15

Behaviour:
- Reset state: state=IDLE, in_ready=1, out_valid=0, result=0, div_by_zero=0, invalid_op=0.
- FSM states: IDLE, CALC, DONE.
- Acceptance: in_valid && in_ready at a rising edge latches the op and operands. in_ready=1 only in IDLE; no accept in DONE.
- W ops when WIDTH==64:
  - Operate on bits [31:0] only (sign- or zero-extended per op); the effective width EW is 32.
  - The 32-bit result is sign-extended to 64.
- W ops when WIDTH==32: behave identically to their non-W counterparts.
- Otherwise EW=WIDTH.
- Iteration count: N = EW/UNROLL.
- Normal path: IDLE -> CALC on accept. CALC runs exactly N cycles, then moves to DONE. out_valid=1 is first seen N+1 edges after the accept edge.
- Fast paths (IDLE -> DONE directly, so out_valid follows one edge after accept):
  - Divisor zero: DIV/DIVU quotient = all ones; REM/REMU result = dividend; div_by_zero=1.
  - Signed overflow (DIV/REM, dividend = most-negative EW value, divisor = -1): quotient = dividend, remainder = 0.
  - Invalid op: result=0, invalid_op=1.
- Multiply:
  - Forms a full 2*EW product; signedness is handled by sign-correcting the operands and the result.
  - MUL/MULW take the low EW bits.
  - MULH/MULHSU/MULHU take the high EW bits.
- Divide:
  - Signed ops use magnitudes. The quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - Identity a = q*b + r must hold.
- DONE: result and flags are held stable while out_valid=1 and out_ready=0. A DONE edge with out_ready=1 returns the FSM to IDLE and clears out_valid and the flags; result keeps its last value.
- flush:
  - From any state, returns to IDLE next edge with out_valid=0, discarding the op.
  - flush has priority over a simultaneous accept: no op is latched.
- rst: overrides flush and any in-flight op. The unit restores reset values next edge, including mid-CALC.
- Iteration counter width: clog2(N)+1. There is no wrap: CALC exits when the counter reaches N.
- Unused upper op_a/op_b bits for W ops do not affect the result.

Test Plan:
- WIDTH=64, UNROLL=1: MUL 7 x -3 -> result 0xFFFF_FFFF_FFFF_FFEB; out_valid first seen 65 edges after the accept edge.
- MULHU 0xFFFF_FFFF_FFFF_FFFF x 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. MULHSU -1 x 2 -> 0xFFFF_FFFF_FFFF_FFFF.
- Divide-by-zero and signed overflow:
  - DIV 100 / 0 -> result all ones, div_by_zero=1, out_valid one edge after accept.
  - REMU 100 % 0 -> 100, div_by_zero=1.
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
  - REM of the same operands -> 0.
- W ops and sign rules:
  - DIVW op_a=0xDEAD_BEEF_FFFF_FFF9 (low -7) / 2 -> 0xFFFF_FFFF_FFFF_FFFD, latency 33 edges.
  - REMW same operands -> 0xFFFF_FFFF_FFFF_FFFF.
  - MULW 0x7FFF_FFFF x 2 -> 0xFFFF_FFFF_FFFF_FFFE.
- Backpressure and handshake:
  - out_ready held 0 for 10 cycles after completion -> result stable and in_ready=0 throughout.
  - out_ready=1 -> IDLE next edge.
  - in_valid asserted during CALC -> not accepted.
- flush, reset and invalid op:
  - flush at CALC cycle 20 -> IDLE next edge, no out_valid; a following MUL 3 x 5 -> 15.
  - rst mid-CALC -> all outputs return to reset values next edge.
  - md_op=14 -> invalid_op=1, result=0.
- UNROLL=4 variant: DIVU 1000 / 7 -> 142 in 17 edges; REMU 1000 % 7 -> 6.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Iterative M-extension multiply/divide unit (RV32M/RV64M including W ops).
// Shift-add multiplier and restoring divider share one IDLE/CALC/DONE handshake FSM.
module alu_muldiv_seq #(
  parameter int WIDTH  = 64,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             invalid_op
);

  localparam int N_FULL = WIDTH / UNROLL;
  localparam int N_HALF = 32 / UNROLL;
  localparam int CNT_W  = $clog2(N_FULL) + 1;

  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_DIVU   = 4'd5;
  localparam logic [3:0] OP_REM    = 4'd6;
  localparam logic [3:0] OP_REMU   = 4'd7;
  localparam logic [3:0] OP_MULW   = 4'd8;
  localparam logic [3:0] OP_DIVW   = 4'd9;
  localparam logic [3:0] OP_DIVUW  = 4'd10;
  localparam logic [3:0] OP_REMW   = 4'd11;
  localparam logic [3:0] OP_REMUW  = 4'd12;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  if (!((WIDTH == 32 || WIDTH == 64) && (UNROLL == 1 || UNROLL == 2 || UNROLL == 4)))
  begin : g_bad_param
    $error("alu_muldiv_seq: unsupported WIDTH/UNROLL combination");
  end

  // Extend the low 32 bits of v to WIDTH, signed or unsigned.
  function automatic logic [WIDTH-1:0] ext32(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [31:0] lo;
    lo = v[31:0];
    if (sgn) return WIDTH'(lo);
    return WIDTH'(v[31:0]);
  endfunction

  function automatic logic [WIDTH-1:0] sext_w(input logic [WIDTH-1:0] v, input logic ew32);
    if (ew32) return ext32(v, 1'b1);
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t state_q, state_d;

  logic dec_mul, dec_div, dec_rem, dec_hi, dec_as, dec_bs, dec_w, dec_inv;
  logic ew32_in, neg_a, neg_b, fast_dbz, fast_ovf, fast, accept;
  logic [WIDTH-1:0] ext_a, ext_b, mag_a, mag_b, min_ew, fast_raw, fast_res;

  logic               mul_q, rem_sel_q, hi_q, neg_q, ew32_q;
  logic [WIDTH-1:0]   opa_q, opb_q, quo_q, quo_n;
  logic [WIDTH:0]     rem_q, rem_n;
  logic [2*WIDTH:0]   acc_q, acc_n;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_raw, fin_res;
  logic [CNT_W-1:0]   cnt_q, cnt_nx, n_lim;
  logic [WIDTH-1:0]   result_q;
  logic               dbz_q, inv_q;

  // Op decode: dec_div covers both quotient and remainder ops.
  always_comb begin
    dec_mul = 1'b0; dec_div = 1'b0; dec_rem = 1'b0; dec_hi = 1'b0;
    dec_as  = 1'b0; dec_bs  = 1'b0; dec_w   = 1'b0; dec_inv = 1'b0;
    case (md_op)
      OP_MUL:    dec_mul = 1'b1;
      OP_MULH:   begin dec_mul = 1'b1; dec_hi = 1'b1; dec_as = 1'b1; dec_bs = 1'b1; end
      OP_MULHSU: begin dec_mul = 1'b1; dec_hi = 1'b1; dec_as = 1'b1; end
      OP_MULHU:  begin dec_mul = 1'b1; dec_hi = 1'b1; end
      OP_DIV:    begin dec_div = 1'b1; dec_as = 1'b1; dec_bs = 1'b1; end
      OP_DIVU:   dec_div = 1'b1;
      OP_REM:    begin dec_div = 1'b1; dec_rem = 1'b1; dec_as = 1'b1; dec_bs = 1'b1; end
      OP_REMU:   begin dec_div = 1'b1; dec_rem = 1'b1; end
      OP_MULW:   begin dec_mul = 1'b1; dec_w = 1'b1; end
      OP_DIVW:   begin dec_div = 1'b1; dec_as = 1'b1; dec_bs = 1'b1; dec_w = 1'b1; end
      OP_DIVUW:  begin dec_div = 1'b1; dec_w = 1'b1; end
      OP_REMW:   begin dec_div = 1'b1; dec_rem = 1'b1; dec_as = 1'b1; dec_bs = 1'b1; dec_w = 1'b1; end
      OP_REMUW:  begin dec_div = 1'b1; dec_rem = 1'b1; dec_w = 1'b1; end
      default:   dec_inv = 1'b1;
    endcase
  end

  // Operand preparation: W ops see only bits [31:0]; signed ops work on magnitudes.
  assign ew32_in = (WIDTH == 64) && dec_w;
  assign ext_a   = ew32_in ? ext32(op_a, dec_as) : op_a;
  assign ext_b   = ew32_in ? ext32(op_b, dec_bs) : op_b;
  assign neg_a   = dec_as && ext_a[WIDTH-1];
  assign neg_b   = dec_bs && ext_b[WIDTH-1];
  assign mag_a   = abs_val(ext_a, neg_a);
  assign mag_b   = abs_val(ext_b, neg_b);
  assign min_ew  = ew32_in ? ({WIDTH{1'b1}} << 31) : ({WIDTH{1'b1}} << (WIDTH - 1));

  assign fast_dbz = dec_div && (ext_b == '0);
  assign fast_ovf = dec_div && dec_as && dec_bs && (ext_a == min_ew) && (ext_b == '1);
  assign fast     = dec_inv || fast_dbz || fast_ovf;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    fast_raw = '0;
    if (fast_dbz)      fast_raw = dec_rem ? ext_a : '1;
    else if (fast_ovf) fast_raw = dec_rem ? '0 : ext_a;
    fast_res = sext_w(fast_raw, ew32_in);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign cnt_nx = cnt_q + CNT_W'(1);
  assign n_lim  = ew32_q ? CNT_W'(N_HALF) : CNT_W'(N_FULL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = fast ? DONE : CALC;
      CALC: if (cnt_nx == n_lim) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    div_by_zero = (state_q == DONE) && dbz_q;
    invalid_op  = (state_q == DONE) && inv_q;
    result      = result_q;
  end

  // One CALC cycle retires UNROLL multiplier or quotient bits.
  always_comb begin
    acc_n = acc_q;
    rem_n = rem_q;
    quo_n = quo_q;
    for (int k = 0; k < UNROLL; k++) begin
      if (mul_q) begin
        if (acc_n[0]) acc_n[2*WIDTH:WIDTH] = acc_n[2*WIDTH:WIDTH] + {1'b0, opa_q};
        acc_n = acc_n >> 1;
      end else begin
        rem_n = {rem_n[WIDTH-1:0], quo_n[WIDTH-1]};
        quo_n = {quo_n[WIDTH-2:0], 1'b0};
        if (rem_n >= {1'b0, opb_q}) begin
          rem_n    = rem_n - {1'b0, opb_q};
          quo_n[0] = 1'b1;
        end
      end
    end
  end

  // A 32-iteration product in the wide accumulator lands 32 bits up.
  always_comb begin
    prod = ew32_q ? (2*WIDTH)'(acc_n[WIDTH+31:32]) : acc_n[2*WIDTH-1:0];
    if (neg_q) prod = -prod;
    if (mul_q)          fin_raw = hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    else if (rem_sel_q) fin_raw = abs_val(rem_n[WIDTH-1:0], neg_q);
    else                fin_raw = abs_val(quo_n, neg_q);
    fin_res = sext_w(fin_raw, ew32_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else if (accept) begin
      cnt_q <= '0;
      dbz_q <= fast_dbz;
      inv_q <= dec_inv;
      if (fast) result_q <= fast_res;
    end else if (state_q == CALC && !flush) begin
      cnt_q <= cnt_nx;
      if (cnt_nx == n_lim) result_q <= fin_res;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      opa_q     <= mag_a;
      opb_q     <= mag_b;
      acc_q     <= {{(WIDTH+1){1'b0}}, mag_b};
      rem_q     <= '0;
      quo_q     <= ew32_in ? (mag_a << (WIDTH - 32)) : mag_a;
      mul_q     <= dec_mul;
      rem_sel_q <= dec_rem;
      hi_q      <= dec_hi;
      ew32_q    <= ew32_in;
      neg_q     <= dec_rem ? neg_a : (neg_a ^ neg_b);
    end else if (state_q == CALC) begin
      acc_q <= acc_n;
      rem_q <= rem_n;
      quo_q <= quo_n;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: vector table on a UNROLL=1 and a UNROLL=4 instance,
// plus hand-written handshake, flush and reset sequences.
module tb_alu_muldiv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready, sel4;
  logic [3:0]  md_op;
  logic [63:0] op_a, op_b;
  logic        rdy1, ov1, dz1, iv1, rdy4, ov4, dz4, iv4;
  logic [63:0] res1, res4;
  logic        rdy, ov, dz, iv;
  logic [63:0] res;

  assign rdy = sel4 ? rdy4 : rdy1;
  assign ov  = sel4 ? ov4  : ov1;
  assign dz  = sel4 ? dz4  : dz1;
  assign iv  = sel4 ? iv4  : iv1;
  assign res = sel4 ? res4 : res1;

  alu_muldiv_seq #(.WIDTH(64), .UNROLL(1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid && !sel4), .in_ready(rdy1),
    .md_op(md_op), .op_a(op_a), .op_b(op_b), .out_valid(ov1), .out_ready(out_ready && !sel4),
    .result(res1), .div_by_zero(dz1), .invalid_op(iv1));

  alu_muldiv_seq #(.WIDTH(64), .UNROLL(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid && sel4), .in_ready(rdy4),
    .md_op(md_op), .op_a(op_a), .op_b(op_b), .out_valid(ov4), .out_ready(out_ready && sel4),
    .result(res4), .div_by_zero(dz4), .invalid_op(iv4));

  typedef struct {
    string       name;
    bit          s4;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    int          lat;
    logic [63:0] r;
    logic        dz;
    logic        iv;
  } vec_t;

  vec_t vecs[$];
  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 64'(act), 64'(exp));
  endtask

  task automatic add(input string nm, input bit s4, input logic [3:0] op, input logic [63:0] a,
                     input logic [63:0] b, input int lat, input logic [63:0] r,
                     input logic dzv, input logic ivv);
    vecs.push_back('{nm, s4, op, a, b, lat, r, dzv, ivv});
  endtask

  // Launch one op and count edges (accept edge = 1) until out_valid, bounded.
  task automatic do_op(input string nm, input bit s4, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, output int lat);
    @(negedge clk);
    sel4 = s4; md_op = op; op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b0;
    chk1({nm, " in_ready before accept"}, rdy, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!ov && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk1({nm, " out_valid cleared"}, ov, 1'b0);
    chk1({nm, " in_ready back"}, rdy, 1'b1);
    chk1({nm, " div_by_zero cleared"}, dz, 1'b0);
    chk1({nm, " invalid_op cleared"}, iv, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel4 = 1'b0;
    md_op = 4'd0; op_a = '0; op_b = '0;

    add("MUL 7*-3",        0, 4'd0,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 65, 64'hFFFF_FFFF_FFFF_FFEB, 0, 0);
    add("MULHU max*max",   0, 4'd3,  '1, '1, 65, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    add("MULHSU -1*2",     0, 4'd2,  '1, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    add("MULH -1*-1",      0, 4'd1,  '1, '1, 65, 64'd0, 0, 0);
    add("MULH min*2",      0, 4'd1,  64'h8000_0000_0000_0000, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    add("DIV 100/0",       0, 4'd4,  64'd100, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    add("REMU 100%0",      0, 4'd7,  64'd100, 64'd0, 1, 64'd100, 1, 0);
    add("DIV min/-1",      0, 4'd4,  64'h8000_0000_0000_0000, '1, 1, 64'h8000_0000_0000_0000, 0, 0);
    add("REM min%-1",      0, 4'd6,  64'h8000_0000_0000_0000, '1, 1, 64'd0, 0, 0);
    add("DIV -20/6",       0, 4'd4,  64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 65, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0);
    add("REM -20%6",       0, 4'd6,  64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 65, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    add("DIVW -7/2",       0, 4'd9,  64'hDEAD_BEEF_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0);
    add("REMW -7%2",       0, 4'd11, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    add("MULW 7fffffff*2", 0, 4'd8,  64'h0000_0000_7FFF_FFFF, 64'hAAAA_0000_0000_0002, 33, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    add("DIVUW ffffffff/1",0, 4'd10, 64'h1234_0000_FFFF_FFFF, 64'd1, 33, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    add("DIVW 5/0low",     0, 4'd9,  64'd5, 64'h1234_5678_0000_0000, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    add("REMUW 7%0low",    0, 4'd12, 64'h0000_0001_0000_0007, 64'h0000_0001_0000_0000, 1, 64'd7, 1, 0);
    add("op 14 invalid",   0, 4'd14, 64'd9, 64'd3, 1, 64'd0, 0, 1);
    add("U4 DIVU 1000/7",  1, 4'd5,  64'd1000, 64'd7, 17, 64'd142, 0, 0);
    add("U4 REMU 1000%7",  1, 4'd7,  64'd1000, 64'd7, 17, 64'd6, 0, 0);
    add("U4 MUL 1234*10",  1, 4'd0,  64'h1234, 64'h10, 17, 64'h12340, 0, 0);
    add("U4 MULH -1*1",    1, 4'd1,  '1, 64'd1, 17, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk1("reset in_ready u1", rdy1, 1'b1);
    chk1("reset out_valid u1", ov1, 1'b0);
    chk("reset result u1", res1, 64'd0);
    chk1("reset div_by_zero u1", dz1, 1'b0);
    chk1("reset invalid_op u1", iv1, 1'b0);
    chk1("reset in_ready u4", rdy4, 1'b1);
    chk1("reset out_valid u4", ov4, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].name, vecs[i].s4, vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk({vecs[i].name, " latency"}, 64'(lat), 64'(vecs[i].lat));
      chk({vecs[i].name, " result"}, res, vecs[i].r);
      chk1({vecs[i].name, " div_by_zero"}, dz, vecs[i].dz);
      chk1({vecs[i].name, " invalid_op"}, iv, vecs[i].iv);
      release_out(vecs[i].name);
    end
    sel4 = 1'b0;

    // Backpressure: result and in_ready held while out_ready stays low.
    do_op("bp MUL 3*5", 0, 4'd0, 64'd3, 64'd5, lat);
    chk("bp latency", 64'(lat), 64'd65);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk1("bp out_valid held", ov, 1'b1);
      chk("bp result held", res, 64'd15);
      chk1("bp in_ready low", rdy, 1'b0);
    end
    release_out("bp");

    // A second request held during CALC is ignored.
    @(negedge clk);
    md_op = 4'd0; op_a = 64'd7; op_b = 64'hFFFF_FFFF_FFFF_FFFD; in_valid = 1'b1;
    @(posedge clk); #1;
    op_a = 64'd2; op_b = 64'd2;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      lat++;
      chk1("busy in_ready low", rdy, 1'b0);
    end
    in_valid = 1'b0;
    while (!ov && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy latency", 64'(lat), 64'd65);
    chk("busy result", res, 64'hFFFF_FFFF_FFFF_FFEB);
    release_out("busy");

    // Flush in CALC cycle 20 drops the op.
    @(negedge clk);
    md_op = 4'd0; op_a = 64'h123; op_b = 64'h456; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk1("flush out_valid", ov, 1'b0);
    chk1("flush in_ready", rdy, 1'b1);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (ov) seen++;
    end
    chk("flush no late out_valid", 64'(seen), 64'd0);

    // Flush beats a simultaneous accept.
    @(negedge clk);
    md_op = 4'd0; op_a = 64'd3; op_b = 64'd5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk1("flush+accept in_ready", rdy, 1'b1);
    @(posedge clk); #1;
    chk1("flush+accept out_valid", ov, 1'b0);
    do_op("post-flush MUL 3*5", 0, 4'd0, 64'd3, 64'd5, lat);
    chk("post-flush latency", 64'(lat), 64'd65);
    chk("post-flush result", res, 64'd15);
    release_out("post-flush");

    // Reset in the middle of CALC.
    @(negedge clk);
    md_op = 4'd0; op_a = 64'd7; op_b = 64'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("midrst in_ready", rdy, 1'b1);
    chk1("midrst out_valid", ov, 1'b0);
    chk("midrst result", res, 64'd0);
    chk1("midrst div_by_zero", dz, 1'b0);
    chk1("midrst invalid_op", iv, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
